// File: rtl/axi4_wr_aux_gen_no_resp_pkg.sv
// Shared AXI write-path definitions: FSM states, burst-type encodings and
// the AWSIZE helper used by the descriptor-to-AW converter.
package axi4_wr_aux_gen_no_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } wr_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Bytes-per-beat exponent for a power-of-two data width of at least 8 bits.
  function automatic logic [2:0] awsize(input int dsize);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if ((8 << i) == dsize) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4_wr_aux_gen_no_resp.sv
// Turns {id, addr, len} descriptors into single AW handshakes and opens the
// external W-path valve until the burst's wlast handshake; B is not observed.
module axi4_wr_aux_gen_no_resp
  import axi4_wr_aux_gen_no_resp_pkg::*;
#(
  parameter int IDSIZE = 4,
  parameter int ASIZE  = 32,
  parameter int LSIZE  = 9,
  parameter int DSIZE  = 32
) (
  input  logic                          axi_aclk,
  input  logic                          axi_areset,
  input  logic                          id_add_len_in_tvalid,
  output logic                          id_add_len_in_tready,
  input  logic [IDSIZE+ASIZE+LSIZE-1:0] id_add_len_in_tdata,
  input  logic                          id_add_len_in_tlast,
  output logic [IDSIZE-1:0]             axi_awid,
  output logic [ASIZE-1:0]              axi_awaddr,
  output logic [LSIZE-1:0]              axi_awlen,
  output logic [2:0]                    axi_awsize,
  output logic [1:0]                    axi_awburst,
  output logic                          axi_awvalid,
  input  logic                          axi_awready,
  input  logic                          axi_wvalid,
  input  logic                          axi_wready,
  input  logic                          axi_wlast,
  output logic                          stream_en
);

  localparam int DW = IDSIZE + ASIZE + LSIZE;

  wr_state_t state;
  logic      desc_hs;
  logic      aw_hs;
  logic      wlast_hs;
  logic      unused_tlast;

  // Descriptors are one beat each, so the stream framing bit carries nothing.
  assign unused_tlast = id_add_len_in_tlast;

  assign desc_hs  = id_add_len_in_tvalid & id_add_len_in_tready;
  assign aw_hs    = axi_awvalid & axi_awready;
  assign wlast_hs = axi_wvalid & axi_wready & axi_wlast;

  assign axi_awsize  = awsize(DSIZE);
  assign axi_awburst = BURST_INCR;

  // tready is a register so it stays low through reset and rises one cycle after release.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state                <= ST_IDLE;
      id_add_len_in_tready <= 1'b0;
      axi_awvalid          <= 1'b0;
      stream_en            <= 1'b0;
      axi_awid             <= '0;
      axi_awaddr           <= '0;
      axi_awlen            <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (desc_hs) begin
            axi_awid             <= id_add_len_in_tdata[DW-1 -: IDSIZE];
            axi_awaddr           <= id_add_len_in_tdata[ASIZE+LSIZE-1 -: ASIZE];
            axi_awlen            <= id_add_len_in_tdata[LSIZE-1:0];
            axi_awvalid          <= 1'b1;
            id_add_len_in_tready <= 1'b0;
            state                <= ST_ADDR;
          end else begin
            id_add_len_in_tready <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (aw_hs) begin
            axi_awvalid <= 1'b0;
            stream_en   <= 1'b1;
            state       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wlast_hs) begin
            stream_en            <= 1'b0;
            id_add_len_in_tready <= 1'b1;
            state                <= ST_IDLE;
          end
        end
        default: begin
          id_add_len_in_tready <= 1'b0;
          axi_awvalid          <= 1'b0;
          stream_en            <= 1'b0;
          state                <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_wr_aux_gen_no_resp.sv
// Bench for axi4_wr_aux_gen_no_resp: burst-level reference model checked every
// cycle, a vector table of bursts, and sequences for reset, back-to-back and W stalls.
module tb_axi4_wr_aux_gen_no_resp;

  localparam int IDSIZE = 4;
  localparam int ASIZE  = 32;
  localparam int LSIZE  = 9;
  localparam int DSIZE  = 32;
  localparam int DW     = IDSIZE + ASIZE + LSIZE;

  typedef logic [DW-1:0] desc_t;

  typedef struct {
    logic [IDSIZE-1:0] id;
    logic [ASIZE-1:0]  addr;
    logic [LSIZE-1:0]  len;
    int                stall;
    bit                stray;
    int                exp_aw;
    int                exp_en;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tvalid = 1'b0;
  logic              tready;
  desc_t             tdata = '0;
  logic              tlast = 1'b0;
  logic [IDSIZE-1:0] awid;
  logic [ASIZE-1:0]  awaddr;
  logic [LSIZE-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready = 1'b0;
  logic              wvalid = 1'b0;
  logic              wready = 1'b0;
  logic              wlast = 1'b0;
  logic              stream_en;

  always #5 clk = ~clk;

  axi4_wr_aux_gen_no_resp #(
    .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE)
  ) dut (
    .axi_aclk(clk),
    .axi_areset(rst),
    .id_add_len_in_tvalid(tvalid),
    .id_add_len_in_tready(tready),
    .id_add_len_in_tdata(tdata),
    .id_add_len_in_tlast(tlast),
    .axi_awid(awid),
    .axi_awaddr(awaddr),
    .axi_awlen(awlen),
    .axi_awsize(awsize),
    .axi_awburst(awburst),
    .axi_awvalid(awvalid),
    .axi_awready(awready),
    .axi_wvalid(wvalid),
    .axi_wready(wready),
    .axi_wlast(wlast),
    .stream_en(stream_en)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: one burst outstanding at a time, tracked as
  // "a descriptor is owned" plus "its address phase has been accepted".
  desc_t             desc_q[$];
  logic [IDSIZE-1:0] got_ids[$];
  int                rise_cyc[$];
  int                fall_cyc[$];
  bit                e_out, e_awacc, e_tready;
  logic [IDSIZE-1:0] e_id;
  logic [ASIZE-1:0]  e_addr;
  logic [LSIZE-1:0]  e_len;
  int                beats;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("tready",    64'(tready),    64'(e_tready));
    chk("awvalid",   64'(awvalid),   64'(e_out && !e_awacc));
    chk("stream_en", 64'(stream_en), 64'(e_out && e_awacc));
    chk("awid",      64'(awid),      64'(e_id));
    chk("awaddr",    64'(awaddr),    64'(e_addr));
    chk("awlen",     64'(awlen),     64'(e_len));
    chk("awsize",    64'(awsize),    64'd2);
    chk("awburst",   64'(awburst),   64'd1);
  endtask

  task automatic model_clear();
    e_out = 0; e_awacc = 0; e_tready = 0;
    e_id = '0; e_addr = '0; e_len = '0; beats = 0;
    desc_q.delete();
  endtask

  // One clock: resolve handshakes from the inputs in force, advance, compare.
  task automatic step();
    bit acc, awhs, wend, prev_av, prev_en;
    acc  = tvalid && e_tready;
    awhs = e_out && !e_awacc && awready;
    wend = e_out && e_awacc && wvalid && wready && wlast;
    if (awvalid && awready) got_ids.push_back(awid);
    if (e_out && e_awacc && wvalid && wready) beats++;
    prev_av = awvalid;
    prev_en = stream_en;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      {e_id, e_addr, e_len} = desc_q.pop_front();
      e_out = 1; e_awacc = 0; beats = 0;
    end
    if (awhs) e_awacc = 1;
    if (wend) e_out = 0;
    e_tready = !e_out;
    if (!prev_av && awvalid) rise_cyc.push_back(cyc);
    if (prev_en && !stream_en) fall_cyc.push_back(cyc);
    check_all();
  endtask

  task automatic drive_idle();
    tvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
  endtask

  task automatic hold_reset();
    #1;
    model_clear();
    drive_idle();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 0;
    step();
  endtask

  task automatic reset_mid();
    #2;
    rst = 1;
    hold_reset();
  endtask

  task automatic run(input int stall, input bit wrand, input bit stray, input bit tgap,
                     input int budget, input bit expect_done, output int awc, output int enc);
    int seen;
    seen = 0; awc = 0; enc = 0;
    while ((desc_q.size() > 0 || e_out) && budget > 0) begin
      tvalid = (desc_q.size() > 0) && (!tgap || $urandom_range(0, 2) != 0);
      tdata  = tvalid ? desc_q[0] : DW'({$urandom(), $urandom()});
      awready = (stall == 0) || (awvalid && seen >= stall);
      if (awvalid) begin
        awc++;
        seen++;
        if (awready) seen = 0;
      end
      if (stream_en) begin
        enc++;
        wvalid = wrand ? 1'($urandom_range(0, 1)) : 1'b1;
        wready = wrand ? 1'($urandom_range(0, 1)) : 1'b1;
        wlast  = (beats == int'(e_len));
      end else if (stray) begin
        wvalid = 1'($urandom_range(0, 1));
        wready = 1'b1;
        wlast  = 1'b1;
      end else begin
        wvalid = 0; wready = 0; wlast = 0;
      end
      step();
      budget--;
    end
    if (expect_done) chk("burst_timeout", 64'(desc_q.size() > 0 || e_out), 64'd0);
    drive_idle();
  endtask

  vec_t vecs[5];

  initial begin
    int awc, enc, n;

    vecs[0] = '{id: 4'd3,  addr: 32'h0000_1000, len: 9'd15,  stall: 0, stray: 0, exp_aw: 1, exp_en: 16};
    vecs[1] = '{id: 4'd5,  addr: 32'hDEAD_BEE0, len: 9'd0,   stall: 0, stray: 1, exp_aw: 1, exp_en: 1};
    vecs[2] = '{id: 4'd0,  addr: 32'h0000_0040, len: 9'd7,   stall: 5, stray: 0, exp_aw: 6, exp_en: 8};
    vecs[3] = '{id: 4'd10, addr: 32'h0000_0020, len: 9'd3,   stall: 3, stray: 1, exp_aw: 4, exp_en: 4};
    vecs[4] = '{id: 4'd15, addr: 32'hFFFF_FFFC, len: 9'd511, stall: 1, stray: 0, exp_aw: 2, exp_en: 512};

    hold_reset();

    for (int i = 0; i < 5; i++) begin
      desc_q.push_back({vecs[i].id, vecs[i].addr, vecs[i].len});
      run(vecs[i].stall, 0, vecs[i].stray, 0, 2000, 1, awc, enc);
      chk($sformatf("vec%0d_aw_cycles", i), 64'(awc), 64'(vecs[i].exp_aw));
      chk($sformatf("vec%0d_en_cycles", i), 64'(enc), 64'(vecs[i].exp_en));
      step();
    end

    // Back-to-back: tvalid held across both descriptors.
    got_ids.delete(); rise_cyc.delete(); fall_cyc.delete();
    desc_q.push_back({4'd0, 32'h0000_0100, 9'd3});
    desc_q.push_back({4'd1, 32'h0000_0200, 9'd2});
    run(0, 0, 0, 0, 200, 1, awc, enc);
    chk("b2b_aw_count", 64'(got_ids.size()), 64'd2);
    chk("b2b_id0", 64'(got_ids[0]), 64'd0);
    chk("b2b_id1", 64'(got_ids[1]), 64'd1);
    chk("b2b_turnaround", 64'(rise_cyc[1]), 64'(fall_cyc[0] + 1));

    // W stalls on an 8-beat burst.
    desc_q.push_back({4'd9, 32'h0000_4000, 9'd7});
    run(1, 1, 0, 0, 500, 1, awc, enc);
    chk("wstall_en_min", 64'(enc >= 8), 64'd1);

    // Reset while the data phase is open.
    desc_q.push_back({4'd3, 32'h0000_1000, 9'd15});
    run(0, 0, 0, 0, 6, 0, awc, enc);
    chk("pre_reset_in_data", 64'(stream_en), 64'd1);
    reset_mid();

    // Randomized bursts.
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++)
        desc_q.push_back({4'($urandom), 32'($urandom), 9'($urandom_range(0, 15))});
      run($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1000, 1, awc, enc);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
